// File: rtl/jpeg_bit_packer.sv
// JPEG entropy-output packer: code words in MSB-first, bytes out with 0xFF/0x00 stuffing; PACK_BYTE_COUNT_EN adds byte/stuff counters.
// States: RUN accept+extract | STUFF emit 0x00 after 0xFF | PAD 1-fill to byte boundary | DRAIN extract until empty, then flush_done.
module jpeg_bit_packer #(
  parameter int MAX_LEN = 27,
  parameter int BUF_W   = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_code,
  input  logic [4:0]         in_len,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic               busy,
  output logic               flush_done
`ifdef PACK_BYTE_COUNT_EN
  ,
  output logic [31:0]        byte_count,
  output logic [15:0]        stuff_count
`endif
);

  localparam int CW = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {S_RUN, S_STUFF, S_PAD, S_DRAIN} state_t;

  state_t             st_q, ret_q, mode_nx;
  logic [BUF_W-1:0]   acc_q;
  logic [CW-1:0]      cnt_q;
  logic               out_valid_q;
  logic [7:0]         out_byte_q;
  logic               flush_done_q;

  logic [4:0]         len_c;
  logic [CW-1:0]      len_w, app_sh, cnt_app, cnt_ext, pad_n;
  logic [MAX_LEN-1:0] code_m;
  logic [BUF_W-1:0]   acc_app, acc_ext, pad_mask;
  logic               accept, xfer, xfer_ff, out_free, ext_ok, ov_keep;

  assign in_ready   = (st_q == S_RUN) && (cnt_q <= CW'(BUF_W - MAX_LEN));
  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign flush_done = flush_done_q;
  assign busy       = (cnt_q != '0) || out_valid_q || (st_q != S_RUN);

  always_comb begin
    len_c    = (in_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : in_len;
    len_w    = {{(CW-5){1'b0}}, len_c};
    accept   = in_valid && in_ready;
    xfer     = out_valid_q && out_ready;
    xfer_ff  = xfer && (out_byte_q == 8'hFF);
    out_free = !out_valid_q || out_ready;
    ov_keep  = out_valid_q && !out_ready;
    code_m   = in_code & ~({MAX_LEN{1'b1}} << len_c);
    // Only meaningful when accepting: cnt_q <= BUF_W-MAX_LEN keeps the shift non-negative.
    app_sh   = CW'(BUF_W) - cnt_q - len_w;
    acc_app  = acc_q;
    cnt_app  = cnt_q;
    if (accept) begin
      acc_app = acc_q | ({{(BUF_W-MAX_LEN){1'b0}}, code_m} << app_sh);
      cnt_app = cnt_q + len_w;
    end
    ext_ok   = out_free && !xfer_ff && (cnt_q >= CW'(8));
    acc_ext  = acc_app << 8;
    cnt_ext  = cnt_app - CW'(8);
    pad_n    = (cnt_q[2:0] == 3'd0) ? '0 : {{(CW-4){1'b0}}, 4'd8 - {1'b0, cnt_q[2:0]}};
    pad_mask = ({BUF_W{1'b1}} >> cnt_q) & ~({BUF_W{1'b1}} >> (cnt_q + pad_n));
    mode_nx  = (st_q == S_RUN && flush) ? S_PAD : st_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= S_RUN;
      ret_q        <= S_RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'h00;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (st_q)
        S_RUN, S_DRAIN: begin
          acc_q <= ext_ok ? acc_ext : acc_app;
          cnt_q <= ext_ok ? cnt_ext : cnt_app;
          if (xfer_ff) begin
            out_byte_q <= 8'h00;
            st_q       <= S_STUFF;
            ret_q      <= mode_nx;
          end else if (ext_ok) begin
            out_byte_q  <= acc_app[BUF_W-1 -: 8];
            out_valid_q <= 1'b1;
            st_q        <= mode_nx;
          end else begin
            if (xfer) out_valid_q <= 1'b0;
            // Nothing left anywhere: finish the flush without visiting PAD/DRAIN.
            if (mode_nx != S_RUN && cnt_app == '0 && !ov_keep) begin
              st_q         <= S_RUN;
              flush_done_q <= 1'b1;
            end else begin
              st_q <= mode_nx;
            end
          end
        end
        S_STUFF: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            if (ret_q == S_DRAIN && cnt_q == '0) begin
              st_q         <= S_RUN;
              flush_done_q <= 1'b1;
            end else begin
              st_q <= ret_q;
            end
          end
        end
        S_PAD: begin
          acc_q <= acc_q | pad_mask;
          cnt_q <= cnt_q + pad_n;
          if (xfer_ff) begin
            out_byte_q <= 8'h00;
            st_q       <= S_STUFF;
            ret_q      <= S_DRAIN;
          end else begin
            if (xfer) out_valid_q <= 1'b0;
            if (cnt_q == '0 && !ov_keep) begin
              st_q         <= S_RUN;
              flush_done_q <= 1'b1;
            end else begin
              st_q <= S_DRAIN;
            end
          end
        end
        default: st_q <= S_RUN;
      endcase
    end
  end

`ifdef PACK_BYTE_COUNT_EN
  logic [31:0] byte_cnt_q;
  logic [15:0] stuff_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      stuff_cnt_q <= '0;
    end else begin
      if (xfer && byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 32'd1;
      if (xfer && st_q == S_STUFF && stuff_cnt_q != '1) stuff_cnt_q <= stuff_cnt_q + 16'd1;
    end
  end

  assign byte_count  = byte_cnt_q;
  assign stuff_count = stuff_cnt_q;
`endif

endmodule
